// File: rtl/ula_arbitro_rr.sv
// ula_arbitro_rr: two-requester round-robin arbiter and sequencer for the shared,
// purely combinational ULA.
//
// Ports:
//   Clock, Reset          - system clock; synchronous active-high reset.
//   Req{0,1}_Valid/Ready  - operation request handshake per requester.
//   Req{0,1}_A/B/Sel      - operands and ULA operation code per requester.
//   Resp_Valid/Ready      - response handshake towards the consumer.
//   Resp_O/Overflow/Zero  - ULA result and flags captured during EXEC.
//   Resp_Id, Resp_Err     - issuing requester; operation code outside 0..7.
//   Ops_Count             - completed responses, wrapping.
//   ULA_A/B/Sel/Reset     - registered drive to the ULA.
//   ULA_O/Overflow/Zero   - ULA outputs.
module ula_arbitro_rr #(
    parameter int unsigned LARGURA = 6,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Req0_Valid,
    output logic               Req0_Ready,
    input  logic [LARGURA-1:0] Req0_A,
    input  logic [LARGURA-1:0] Req0_B,
    input  logic [SEL_W-1:0]   Req0_Sel,
    input  logic               Req1_Valid,
    output logic               Req1_Ready,
    input  logic [LARGURA-1:0] Req1_A,
    input  logic [LARGURA-1:0] Req1_B,
    input  logic [SEL_W-1:0]   Req1_Sel,
    output logic               Resp_Valid,
    input  logic               Resp_Ready,
    output logic [LARGURA-1:0] Resp_O,
    output logic               Resp_Overflow,
    output logic               Resp_Zero,
    output logic               Resp_Id,
    output logic               Resp_Err,
    output logic [CNT_W-1:0]   Ops_Count,
    output logic [LARGURA-1:0] ULA_A,
    output logic [LARGURA-1:0] ULA_B,
    output logic [SEL_W-1:0]   ULA_Sel,
    output logic               ULA_Reset,
    input  logic [LARGURA-1:0] ULA_O,
    input  logic               ULA_Overflow,
    input  logic               ULA_Zero
);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               ultimo_q, ultimo_d;  // last granted requester
    logic [LARGURA-1:0] a_q, a_d, b_q, b_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               id_q, id_d;
    logic [LARGURA-1:0] resp_o_q, resp_o_d;
    logic               resp_ov_q, resp_ov_d;
    logic               resp_zero_q, resp_zero_d;
    logic               resp_err_q, resp_err_d;
    logic [CNT_W-1:0]   ops_count_q, ops_count_d;
    logic               idle;

    // On a tie the requester that did not win last time is granted.
    assign idle       = (state_q == OCIOSO) && !Reset;
    assign Req0_Ready = idle && Req0_Valid && (!Req1_Valid || ultimo_q);
    assign Req1_Ready = idle && Req1_Valid && (!Req0_Valid || !ultimo_q);

    always_comb begin
        state_d     = state_q;
        ultimo_d    = ultimo_q;
        a_d         = a_q;
        b_d         = b_q;
        sel_d       = sel_q;
        id_d        = id_q;
        resp_o_d    = resp_o_q;
        resp_ov_d   = resp_ov_q;
        resp_zero_d = resp_zero_q;
        resp_err_d  = resp_err_q;
        ops_count_d = ops_count_q;
        case (state_q)
            OCIOSO: begin
                if (Req0_Ready || Req1_Ready) begin
                    a_d      = Req1_Ready ? Req1_A : Req0_A;
                    b_d      = Req1_Ready ? Req1_B : Req0_B;
                    sel_d    = Req1_Ready ? Req1_Sel : Req0_Sel;
                    id_d     = Req1_Ready;
                    ultimo_d = Req1_Ready;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // ULA has settled on the registered operands during this cycle.
                resp_o_d    = ULA_O;
                resp_ov_d   = ULA_Overflow;
                resp_zero_d = ULA_Zero;
                resp_err_d  = (sel_q > SEL_W'(7));
                state_d     = RESP;
            end
            RESP: begin
                if (Resp_Ready) begin
                    ops_count_d = ops_count_q + CNT_W'(1);
                    state_d     = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= OCIOSO;
            ultimo_q    <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            id_q        <= 1'b0;
            resp_o_q    <= '0;
            resp_ov_q   <= 1'b0;
            resp_zero_q <= 1'b0;
            resp_err_q  <= 1'b0;
            ops_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ultimo_q    <= ultimo_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            id_q        <= id_d;
            resp_o_q    <= resp_o_d;
            resp_ov_q   <= resp_ov_d;
            resp_zero_q <= resp_zero_d;
            resp_err_q  <= resp_err_d;
            ops_count_q <= ops_count_d;
        end
    end

    assign Resp_Valid    = (state_q == RESP);
    assign Resp_O        = resp_o_q;
    assign Resp_Overflow = resp_ov_q;
    assign Resp_Zero     = resp_zero_q;
    assign Resp_Id       = id_q;
    assign Resp_Err      = resp_err_q;
    assign Ops_Count     = ops_count_q;

    assign ULA_A     = a_q;
    assign ULA_B     = b_q;
    assign ULA_Sel   = sel_q;
    // Holding the ULA in reset outside EXEC parks it at O=0, Zero=1.
    assign ULA_Reset = Reset || (state_q != EXEC);

endmodule

// File: tb/tb_ula_arbitro_rr.sv
module tb_ula_arbitro_rr;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
    logic [5:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic [3:0] Req0_Sel, Req1_Sel;
    logic       Resp_Valid, Resp_Ready;
    logic [5:0] Resp_O;
    logic       Resp_Overflow, Resp_Zero, Resp_Id, Resp_Err;
    logic [7:0] Ops_Count;
    logic [5:0] ULA_A, ULA_B;
    logic [3:0] ULA_Sel;
    logic       ULA_Reset;
    logic [5:0] ula_o;
    logic       ula_ov, ula_z;

    always #5 Clock = ~Clock;

    ula_arbitro_rr dut (
        .Clock(Clock), .Reset(Reset),
        .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_A(Req0_A), .Req0_B(Req0_B),
        .Req0_Sel(Req0_Sel),
        .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_A(Req1_A), .Req1_B(Req1_B),
        .Req1_Sel(Req1_Sel),
        .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_O(Resp_O),
        .Resp_Overflow(Resp_Overflow), .Resp_Zero(Resp_Zero), .Resp_Id(Resp_Id),
        .Resp_Err(Resp_Err), .Ops_Count(Ops_Count),
        .ULA_A(ULA_A), .ULA_B(ULA_B), .ULA_Sel(ULA_Sel), .ULA_Reset(ULA_Reset),
        .ULA_O(ula_o), .ULA_Overflow(ula_ov), .ULA_Zero(ula_z)
    );

    // Stand-in ULA; returns {Overflow, Zero, O}.
    function automatic logic [7:0] ula_fn(input logic [5:0] a, input logic [5:0] b,
                                          input logic [3:0] sel);
        logic [6:0] s;
        logic [5:0] o;
        logic       ov;
        o  = '0;
        ov = 1'b0;
        case (sel)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; o = s[5:0]; ov = s[6]; end
            4'd1: begin o = a - b; ov = (a < b); end
            4'd2: o = a & b;
            4'd3: o = a | b;
            4'd4: if (a == 6'd63) begin o = a; ov = 1'b1; end else o = a + 6'd1;
            4'd5: o = a ^ b;
            4'd6: o = ~a;
            4'd7: o = b;
            default: begin o = '0; ov = 1'b0; end
        endcase
        return {ov, (o == 6'd0) && !ov, o};
    endfunction

    always_comb begin
        {ula_ov, ula_z, ula_o} = ULA_Reset ? 8'b0100_0000 : ula_fn(ULA_A, ULA_B, ULA_Sel);
    end

    // Transaction-level model: at most one operation outstanding, aged in cycles since grant.
    bit         m_ok = 1'b0;
    bit         m_busy, m_id, m_last;
    int         m_age, m_count;
    logic [5:0] m_a, m_b;
    logic [3:0] m_sel;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {Req1_Ready, Req0_Ready} the rules demand for the current inputs.
    function automatic logic [1:0] exp_ready();
        if (Reset || m_busy) return 2'b00;
        if (Req0_Valid && Req1_Valid) return m_last ? 2'b01 : 2'b10;
        return {Req1_Valid, Req0_Valid};
    endfunction

    task automatic compare();
        logic [1:0] r;
        logic [7:0] res;
        bit         v;
        @(negedge Clock);
        if (!m_ok) return;
        r   = exp_ready();
        v   = m_busy && (m_age >= 2);
        res = ula_fn(m_a, m_b, m_sel);
        chk("req0_ready", Req0_Ready, r[0]);
        chk("req1_ready", Req1_Ready, r[1]);
        if (!Reset) chk("resp_valid", Resp_Valid, v);
        if (v && !Reset) begin
            chk("resp_o", Resp_O, res[5:0]);
            chk("resp_ov", Resp_Overflow, res[7]);
            chk("resp_zero", Resp_Zero, res[6]);
            chk("resp_err", Resp_Err, m_sel >= 4'd8);
        end
        chk("resp_id", Resp_Id, m_id);
        chk("ops_count", Ops_Count, m_count);
        chk("ula_a", ULA_A, m_a);
        chk("ula_b", ULA_B, m_b);
        chk("ula_sel", ULA_Sel, m_sel);
        chk("ula_reset", ULA_Reset, Reset || !(m_busy && m_age == 1));
    endtask

    task automatic advance();
        logic [1:0] g;
        @(posedge Clock);
        g = exp_ready();
        if (Reset) begin
            m_ok = 1'b1; m_busy = 1'b0; m_last = 1'b1; m_count = 0;
            m_a = '0; m_b = '0; m_sel = '0; m_id = 1'b0;
        end else if (m_busy) begin
            if (m_age >= 2 && Resp_Ready) begin
                m_busy  = 1'b0;
                m_count = (m_count + 1) % 256;
            end else begin
                m_age++;
            end
        end else if (g != 2'b00) begin
            m_busy = 1'b1; m_age = 1; m_id = g[1]; m_last = g[1];
            m_a    = g[1] ? Req1_A : Req0_A;
            m_b    = g[1] ? Req1_B : Req0_B;
            m_sel  = g[1] ? Req1_Sel : Req0_Sel;
        end
        #1;
    endtask

    task automatic step();
        compare();
        advance();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic set_req(input bit id, input bit v, input logic [5:0] a, input logic [5:0] b,
                           input logic [3:0] sel);
        if (id) begin Req1_Valid = v; Req1_A = a; Req1_B = b; Req1_Sel = sel; end
        else    begin Req0_Valid = v; Req0_A = a; Req0_B = b; Req0_Sel = sel; end
    endtask

    task automatic do_op(input bit id, input logic [5:0] a, input logic [5:0] b,
                         input logic [3:0] sel, input logic [5:0] eo, input bit eov,
                         input bit ez, input bit eerr);
        bit got;
        got        = 1'b0;
        Resp_Ready = 1'b1;
        set_req(id, 1'b1, a, b, sel);
        for (int i = 0; i < 20 && !got; i++) begin
            compare();
            if (id ? Req1_Ready : Req0_Ready) got = 1'b1;
            advance();
        end
        set_req(id, 1'b0, a, b, sel);
        chk("op_granted", got, 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            compare();
            if (Resp_Valid) begin
                got = 1'b1;
                chk("op_o", Resp_O, eo);
                chk("op_ov", Resp_Overflow, eov);
                chk("op_zero", Resp_Zero, ez);
                chk("op_id", Resp_Id, id);
                chk("op_err", Resp_Err, eerr);
            end
            advance();
        end
        chk("op_resp_seen", got, 1);
    endtask

    initial begin
        int         ngr, nrs, done;
        logic [5:0] held_o;
        Reset = 1'b1; Resp_Ready = 1'b0;
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Single operations with hand-computed results.
        do_reset();
        do_op(0, 6'd10, 6'd5, 4'd0, 6'd15, 0, 0, 0);
        compare();
        chk("count_after_first", Ops_Count, 1);
        advance();
        do_op(1, 6'd63, 6'd1, 4'd0, 6'd0, 1, 0, 0);
        do_op(0, 6'd3, 6'd0, 4'd8, 6'd0, 0, 1, 1);

        // Both requesters continuously valid from reset: grants must alternate 0,1,0,1.
        set_req(0, 1'b1, 6'd7, 6'd0, 4'd4);
        set_req(1, 1'b1, 6'd63, 6'd0, 4'd4);
        Resp_Ready = 1'b1;
        do_reset();
        ngr = 0; nrs = 0;
        for (int i = 0; i < 40 && nrs < 4; i++) begin
            compare();
            if (Req0_Ready || Req1_Ready) begin
                chk("alt_grant", Req1_Ready, ngr % 2);
                ngr++;
            end
            if (Resp_Valid) begin
                chk("alt_id", Resp_Id, nrs % 2);
                chk("alt_o", Resp_O, (nrs % 2) ? 63 : 8);
                chk("alt_ov", Resp_Overflow, nrs % 2);
                nrs++;
            end
            advance();
        end
        chk("alt_responses", nrs, 4);
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);

        // Backpressure: response held while Req1 waits, Req1 taken the cycle after handshake.
        do_reset();
        Resp_Ready = 1'b0;
        set_req(0, 1'b1, 6'd20, 6'd22, 4'd0);
        set_req(1, 1'b1, 6'd1, 6'd2, 4'd0);
        compare();
        chk("bp_grant0", Req0_Ready, 1);
        advance();
        Req0_Valid = 1'b0;
        step();
        held_o = 6'd42;
        for (int i = 0; i < 5; i++) begin
            compare();
            chk("bp_valid", Resp_Valid, 1);
            chk("bp_o", Resp_O, held_o);
            chk("bp_id", Resp_Id, 0);
            chk("bp_req1_ready", Req1_Ready, 0);
            advance();
        end
        Resp_Ready = 1'b1;
        compare();
        chk("bp_hs_req1_ready", Req1_Ready, 0);
        advance();
        compare();
        chk("bp_after_req1_ready", Req1_Ready, 1);
        advance();
        Req1_Valid = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // Reset during EXEC drops the operation.
        do_reset();
        set_req(0, 1'b1, 6'd1, 6'd1, 4'd0);
        step();
        Req0_Valid = 1'b0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            compare();
            chk("rst_exec_valid", Resp_Valid, 0);
            chk("rst_exec_count", Ops_Count, 0);
            advance();
        end

        // 256 completions wrap the counter.
        do_reset();
        set_req(0, 1'b1, 6'd1, 6'd1, 4'd0);
        set_req(1, 1'b1, 6'd2, 6'd2, 4'd1);
        Resp_Ready = 1'b1;
        done = 0;
        for (int i = 0; i < 1200 && done < 256; i++) begin
            compare();
            if (Resp_Valid) done++;
            advance();
        end
        set_req(0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0);
        chk("wrap_done", done, 256);
        compare();
        chk("wrap_count", Ops_Count, 0);
        advance();

        // Randomized traffic with backpressure and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step();
            Req0_Valid = ($urandom_range(0, 9) < 7);
            Req1_Valid = ($urandom_range(0, 9) < 6);
            Req0_A = 6'($urandom); Req0_B = 6'($urandom); Req0_Sel = 4'($urandom);
            Req1_A = 6'($urandom); Req1_B = 6'($urandom); Req1_Sel = 4'($urandom);
            Resp_Ready = ($urandom_range(0, 9) < 7);
            Reset = ($urandom_range(0, 149) == 0);
        end
        Reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
